pipe_cu: RTL and testbench

Pipelined control unit for the five-stage RV32I core. Decodes the instruction in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. Resolves all six conditional branches in EX from ALU flags, and detects load-use and branch hazards. Drives the stall, flush and forwarding selects for the datapath.

---
 rtl/cu_pkg.sv | 51 +++++
 rtl/cu_decode.sv | 129 ++++++++++++
 rtl/pipe_cu.sv | 106 ++++++++++
 tb/tb_pipe_cu.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcodes, control enums, control bundle and bubble for pipe_cu
package cu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_ctrl_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;

  // Unused source fields are decoded as x0 so they never match a hazard or forward
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    alu_ctrl_t  alu_ctrl;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       is_load;
    logic       illegal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '{
    reg_write: 1'b0, result_src: 2'b00, mem_write: 1'b0, branch: 1'b0,
    jump: 1'b0, jalr: 1'b0, alu_src: 1'b0, alu_ctrl: ALU_ADD,
    funct3: 3'b000, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
    is_load: 1'b0, illegal: 1'b0
  };

  function automatic logic [1:0] fwd_sel(logic [4:0] rs, ctrl_bundle_t m, ctrl_bundle_t w);
    if (rs != 5'd0 && m.reg_write && m.rd == rs) return 2'd2;
    if (rs != 5'd0 && w.reg_write && w.rd == rs) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational instruction to ctrl_bundle_t decoder
// JAL/JALR decode only when PIPE_CU_JUMP_EN is defined.
module cu_decode
  import cu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output imm_src_t     imm_src
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       shamt_zero;
  logic       shamt_sra;
  logic       legal;
  alu_ctrl_t  base_op;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // RV64 shift immediates use instr[25] as shamt[5]
  assign shamt_zero = (XLEN == 64) ? (instr[31:26] == 6'b000000) : (funct7 == 7'b0000000);
  assign shamt_sra  = (XLEN == 64) ? (instr[31:26] == 6'b010000) : (funct7 == 7'b0100000);

  always_comb begin
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    ctrl        = BUBBLE;
    ctrl.funct3 = funct3;
    legal       = 1'b1;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.rs1       = instr[19:15];
        ctrl.rs2       = instr[24:20];
        ctrl.rd        = instr[11:7];
        if (funct7 == 7'b0000000) ctrl.alu_ctrl = base_op;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) ctrl.alu_ctrl = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) ctrl.alu_ctrl = ALU_SRA;
        else legal = 1'b0;
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.rs1       = instr[19:15];
        ctrl.rd        = instr[11:7];
        ctrl.alu_ctrl  = base_op;
        if (funct3 == 3'b001) legal = shamt_zero;
        else if (funct3 == 3'b101 && shamt_sra) ctrl.alu_ctrl = ALU_SRA;
        else if (funct3 == 3'b101) legal = shamt_zero;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = 2'd1;
        ctrl.alu_src    = 1'b1;
        ctrl.is_load    = 1'b1;
        ctrl.rs1        = instr[19:15];
        ctrl.rd         = instr[11:7];
        legal           = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.rs1       = instr[19:15];
        ctrl.rs2       = instr[24:20];
        legal          = !funct3[2] && (funct3 != 3'b011);
      end
      OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.rs1      = instr[19:15];
        ctrl.rs2      = instr[24:20];
        legal         = (funct3[2:1] != 2'b01);
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.rd        = instr[11:7];
      end
`ifdef PIPE_CU_JUMP_EN
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = 2'd2;
        ctrl.jump       = 1'b1;
        ctrl.rd         = instr[11:7];
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = 2'd2;
        ctrl.jalr       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.rs1        = instr[19:15];
        ctrl.rd         = instr[11:7];
        legal           = (funct3 == 3'b000);
      end
`endif
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      ctrl         = BUBBLE;
      ctrl.illegal = 1'b1;
    end
  end

  always_comb begin
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_LUI:    imm_src = IMM_U;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/pipe_cu.sv
// rtl/pipe_cu.sv - RV32I pipelined control unit: ID/EX/MEM/WB control, branches, hazards, forwarding
// PIPE_CU_JUMP_EN enables JAL/JALR redirects.
module pipe_cu
  import cu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_d,
  input  logic                 zero_e,
  input  logic                 lt_e,
  input  logic                 ltu_e,
  output logic [2:0]           imm_src_d,
  output logic [ALUCTRL_W-1:0] alu_ctrl_e,
  output logic                 alu_src_e,
  output logic [1:0]           pc_src_e,
  output logic [1:0]           fwd_a_e,
  output logic [1:0]           fwd_b_e,
  output logic                 mem_write_m,
  output logic                 reg_write_m,
  output logic [REG_AW-1:0]    rd_m,
  output logic                 reg_write_w,
  output logic [REG_AW-1:0]    rd_w,
  output logic [1:0]           result_src_w,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 illegal_e
);

  ctrl_bundle_t dec_d, id_ex, ex_mem, mem_wb;
  imm_src_t     imm_src;
  logic [1:0]   fwd_a, fwd_b;
  logic         taken, load_use, redirect;
  logic         unused_bits;

  cu_decode #(.XLEN(XLEN)) u_decode (.instr(instr_d), .ctrl(dec_d), .imm_src(imm_src));

  assign imm_src_d = imm_src;

  always_comb begin
    case (id_ex.funct3)
      3'b000:  taken = zero_e;
      3'b001:  taken = !zero_e;
      3'b100:  taken = lt_e;
      3'b101:  taken = !lt_e;
      3'b110:  taken = ltu_e;
      3'b111:  taken = !ltu_e;
      default: taken = 1'b0;
    endcase
  end

`ifdef PIPE_CU_JUMP_EN
  always_comb begin
    if (id_ex.jalr) pc_src_e = 2'd2;
    else if (id_ex.jump || (id_ex.branch && taken)) pc_src_e = 2'd1;
    else pc_src_e = 2'd0;
  end
`else
  assign pc_src_e = (id_ex.branch && taken) ? 2'd1 : 2'd0;
`endif

  assign load_use = id_ex.is_load && (id_ex.rd != 5'd0) &&
                    ((id_ex.rd == dec_d.rs1) || (id_ex.rd == dec_d.rs2));
  assign redirect = (pc_src_e != 2'd0);
  // A redirect squashes the stalled instruction anyway, so it wins over the stall
  assign stall_f  = load_use && !redirect;
  assign stall_d  = load_use && !redirect;
  assign flush_d  = redirect;
  assign flush_e  = redirect || load_use;

  // Forward selects are resolved one cycle early against the next MEM/WB occupants
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex  <= BUBBLE;
      ex_mem <= BUBBLE;
      mem_wb <= BUBBLE;
      fwd_a  <= 2'd0;
      fwd_b  <= 2'd0;
    end else begin
      id_ex  <= flush_e ? BUBBLE : dec_d;
      fwd_a  <= flush_e ? 2'd0 : fwd_sel(dec_d.rs1, id_ex, ex_mem);
      fwd_b  <= flush_e ? 2'd0 : fwd_sel(dec_d.rs2, id_ex, ex_mem);
      ex_mem <= id_ex;
      mem_wb <= ex_mem;
    end
  end

  assign alu_ctrl_e   = ALUCTRL_W'(id_ex.alu_ctrl);
  assign alu_src_e    = id_ex.alu_src;
  assign illegal_e    = id_ex.illegal;
  assign fwd_a_e      = fwd_a;
  assign fwd_b_e      = fwd_b;
  assign mem_write_m  = ex_mem.mem_write;
  assign reg_write_m  = ex_mem.reg_write;
  assign rd_m         = REG_AW'(ex_mem.rd);
  assign reg_write_w  = mem_wb.reg_write;
  assign rd_w         = REG_AW'(mem_wb.rd);
  assign result_src_w = mem_wb.result_src;
  assign unused_bits  = ^{id_ex, ex_mem, mem_wb};

endmodule

// File: tb/tb_pipe_cu.sv
// tb/tb_pipe_cu.sv - randomized bench for pipe_cu against a stage-level behavioural model
module tb_pipe_cu;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_d = 32'h0000_0013;
  logic        zero_e = 1'b0, lt_e = 1'b0, ltu_e = 1'b0;
  logic [2:0]  imm_src_d;
  logic [3:0]  alu_ctrl_e;
  logic        alu_src_e, mem_write_m, reg_write_m, reg_write_w;
  logic [1:0]  pc_src_e, fwd_a_e, fwd_b_e, result_src_w;
  logic [4:0]  rd_m, rd_w;
  logic        stall_f, stall_d, flush_d, flush_e, illegal_e;

  pipe_cu dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
    .imm_src_d(imm_src_d), .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e), .pc_src_e(pc_src_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_write_m(mem_write_m), .reg_write_m(reg_write_m),
    .rd_m(rd_m), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_src_w(result_src_w),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .illegal_e(illegal_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rw; bit [1:0] rs; bit mw, br, jp, jr, asrc; int alu; bit [2:0] f3;
    bit [4:0] rs1, rs2, rd; bit u1, u2, ld, ill;
  } rec_t;

  int base_op [8] = '{int'(ALU_ADD), int'(ALU_SLL), int'(ALU_SLT), int'(ALU_SLTU),
                      int'(ALU_XOR), int'(ALU_SRL), int'(ALU_OR), int'(ALU_AND)};
  int checks = 0, errors = 0;
  bit chk_en = 0;
  rec_t m_ex, m_mem, m_wb;
  bit last_stall = 0;
  int e_pc, e_fa, e_fb, e_imm;
  bit e_stall, e_flush_d, e_flush_e;

  function automatic rec_t bubble();
    rec_t r = '{default: 0};
    return r;
  endfunction

  function automatic rec_t mdec(logic [31:0] i);
    rec_t r = '{default: 0};
    bit ok = 1;
    bit [2:0] f3 = i[14:12];
    bit [6:0] f7 = i[31:25];
    r.f3 = f3;
    case (i[6:0])
      7'b0110011: begin
        r.rw = 1; r.u1 = 1; r.u2 = 1; r.alu = base_op[f3];
        if (f7 == 7'h20 && f3 == 0) r.alu = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 5) r.alu = ALU_SRA;
        else if (f7 != 0) ok = 0;
      end
      7'b0010011: begin
        r.rw = 1; r.u1 = 1; r.asrc = 1; r.alu = base_op[f3];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin
          if (f7 == 7'h20) r.alu = ALU_SRA; else ok = (f7 == 0);
        end
      end
      7'b0000011: begin
        r.rw = 1; r.rs = 1; r.asrc = 1; r.u1 = 1; r.ld = 1; ok = f3 inside {0, 1, 2, 4, 5};
      end
      7'b0100011: begin r.mw = 1; r.asrc = 1; r.u1 = 1; r.u2 = 1; ok = (f3 <= 2); end
      7'b1100011: begin r.br = 1; r.u1 = 1; r.u2 = 1; r.alu = ALU_SUB; ok = !(f3 inside {2, 3}); end
      7'b0110111: begin r.rw = 1; r.asrc = 1; end
`ifdef PIPE_CU_JUMP_EN
      7'b1101111: begin r.rw = 1; r.rs = 2; r.jp = 1; end
      7'b1100111: begin r.rw = 1; r.rs = 2; r.jr = 1; r.asrc = 1; r.u1 = 1; ok = (f3 == 0); end
`endif
      default: ok = 0;
    endcase
    if (!ok) begin r = '{default: 0}; r.ill = 1; end
    r.rs1 = r.u1 ? i[19:15] : 5'd0;
    r.rs2 = r.u2 ? i[24:20] : 5'd0;
    r.rd  = r.rw ? i[11:7] : 5'd0;
    return r;
  endfunction

  function automatic bit mtaken(bit [2:0] f3, bit z, bit lt, bit ltu);
    case (f3)
      0: return z;   1: return !z;
      4: return lt;  5: return !lt;
      6: return ltu; 7: return !ltu;
      default: return 0;
    endcase
  endfunction

  function automatic int mfwd(bit [4:0] rs);
    if (rs != 0 && m_mem.rw && m_mem.rd == rs) return 2;
    if (rs != 0 && m_wb.rw && m_wb.rd == rs) return 1;
    return 0;
  endfunction

  task automatic model_eval();
    rec_t d = mdec(instr_d);
    bit lu;
    e_pc = m_ex.jr ? 2 : (((m_ex.br && mtaken(m_ex.f3, zero_e, lt_e, ltu_e)) || m_ex.jp) ? 1 : 0);
    lu = m_ex.ld && m_ex.rd != 0 &&
         ((d.u1 && d.rs1 == m_ex.rd) || (d.u2 && d.rs2 == m_ex.rd));
    e_stall   = lu && e_pc == 0;
    e_flush_d = e_pc != 0;
    e_flush_e = e_pc != 0 || lu;
    e_fa = mfwd(m_ex.rs1);
    e_fb = mfwd(m_ex.rs2);
    case (instr_d[6:0])
      7'b0100011: e_imm = 1;
      7'b1100011: e_imm = 2;
      7'b0110111: e_imm = 3;
      7'b1101111: e_imm = 4;
      default:    e_imm = 0;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); last_stall = 0;
    end else begin
      model_eval();
      last_stall = e_stall;
      m_wb = m_mem;
      m_mem = m_ex;
      m_ex = e_flush_e ? bubble() : mdec(instr_d);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      model_eval();
      chk("imm_src_d", imm_src_d, e_imm);
      chk("alu_ctrl_e", alu_ctrl_e, m_ex.alu);
      chk("alu_src_e", alu_src_e, m_ex.asrc);
      chk("illegal_e", illegal_e, m_ex.ill);
      chk("pc_src_e", pc_src_e, e_pc);
      chk("fwd_a_e", fwd_a_e, e_fa);
      chk("fwd_b_e", fwd_b_e, e_fb);
      chk("mem_write_m", mem_write_m, m_mem.mw);
      chk("reg_write_m", reg_write_m, m_mem.rw);
      chk("rd_m", rd_m, m_mem.rd);
      chk("reg_write_w", reg_write_w, m_wb.rw);
      chk("rd_w", rd_w, m_wb.rd);
      chk("result_src_w", result_src_w, m_wb.rs);
      chk("stall_f", stall_f, e_stall);
      chk("stall_d", stall_d, e_stall);
      chk("flush_d", flush_d, e_flush_d);
      chk("flush_e", flush_e, e_flush_e);
    end
  end

  function automatic logic [31:0] rtype(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] btype(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, f3, 5'b0, 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd = 5'($urandom_range(0, 7));
    logic [4:0] rs1 = 5'($urandom_range(0, 7));
    logic [4:0] rs2 = 5'($urandom_range(0, 7));
    logic [2:0] f3 = 3'($urandom_range(0, 7));
    logic [6:0] f7;
    f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : (($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h00);
    case ($urandom_range(0, 11))
      0, 1:    return {f7, rs2, rs1, f3, rd, 7'b0110011};
      2:       return {f7, rs2, rs1, f3, rd, 7'b0010011};
      3:       return {f7, rs2, rs1, f3, rd, 7'b0000011};
      4:       return {f7, rs2, rs1, f3, rd, 7'b0100011};
      5, 6:    return {f7, rs2, rs1, f3, rd, 7'b1100011};
      7:       return {f7, rs2, rs1, f3, rd, 7'b0110111};
      8:       return {f7, rs2, rs1, f3, rd, 7'b1101111};
      9:       return {f7, rs2, rs1, (f3[2] ? f3 : 3'b000), rd, 7'b1100111};
      10:      return $urandom;
      default: return 32'h0000_0013;
    endcase
  endfunction

  task automatic step(input logic [31:0] ins, input bit z, input bit lt, input bit ltu);
    @(posedge clk); #1;
    instr_d = ins; zero_e = z; lt_e = lt; ltu_e = ltu;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    logic [31:0] add_x1, lw_x5, add_x6, jalr_x1;
    add_x1  = rtype(7'h00, 5'd3, 5'd2, 3'b000, 5'd1);
    lw_x5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    add_x6  = rtype(7'h00, 5'd7, 5'd5, 3'b000, 5'd6);
    jalr_x1 = {12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111};

    rst_n = 0; instr_d = add_x1;
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk);
    @(negedge clk);
    chk("reset all outputs", {imm_src_d, alu_ctrl_e, alu_src_e, pc_src_e, fwd_a_e, fwd_b_e,
        mem_write_m, reg_write_m, rd_m, reg_write_w, rd_w, result_src_w}, 32'd0);
    chk("reset hazards", {stall_f, stall_d, flush_d, flush_e, illegal_e}, 32'd0);
    @(posedge clk); #1 rst_n = 1;
    step(NOP, 0, 0, 0);
    step(NOP, 0, 0, 0);
    @(negedge clk);
    chk("add in MEM not yet WB", {reg_write_m, rd_m, reg_write_w}, {25'd0, 1'b1, 5'd1, 1'b0});
    step(NOP, 0, 0, 0);
    @(negedge clk);
    chk("add reaches WB", {reg_write_w, rd_w}, {26'd0, 1'b1, 5'd1});

    step(btype(3'b100, 5'd2, 5'd3), 0, 0, 0);
    step(NOP, 0, 1, 0);
    @(negedge clk);
    chk("blt taken", {pc_src_e, flush_d, flush_e, stall_f}, {28'd0, 2'd1, 1'b1, 1'b1, 1'b0});
    step(NOP, 0, 0, 0);
    @(negedge clk);
    chk("blt flush one cycle", {pc_src_e, flush_d}, 32'd0);
    step(btype(3'b111, 5'd2, 5'd3), 0, 0, 0);
    step(NOP, 0, 0, 1);
    @(negedge clk);
    chk("bgeu not taken", {pc_src_e, flush_d, flush_e}, 32'd0);

    step(lw_x5, 0, 0, 0);
    step(add_x6, 0, 0, 0);
    @(negedge clk);
    chk("load-use stall", {stall_f, stall_d, flush_e, flush_d}, 32'b1110);
    step(add_x6, 0, 0, 0);
    @(negedge clk);
    chk("stall lasts one cycle", {stall_f, stall_d}, 32'd0);
    step(NOP, 0, 0, 0);
    @(negedge clk);
    chk("load result forwarded from WB", {fwd_a_e, fwd_b_e}, 32'b0100);

    step(rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 0, 0, 0);
    step(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd4), 0, 0, 0);
    step(rtype(7'h00, 5'd4, 5'd4, 3'b110, 5'd8), 0, 0, 0);
    step(NOP, 0, 0, 0);
    @(negedge clk);
    chk("MEM beats WB", {fwd_a_e, fwd_b_e}, 32'b1010);
    step(rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd0), 0, 0, 0);
    step(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 0, 0, 0);
    step(rtype(7'h00, 5'd0, 5'd0, 3'b110, 5'd8), 0, 0, 0);
    step(NOP, 0, 0, 0);
    @(negedge clk);
    chk("x0 never forwards", {fwd_a_e, fwd_b_e}, 32'd0);

    step(jalr_x1, 0, 0, 0);
    step(NOP, 0, 0, 0);
    @(negedge clk);
`ifdef PIPE_CU_JUMP_EN
    chk("jalr redirect", {pc_src_e, illegal_e}, {29'd0, 2'd2, 1'b0});
`else
    chk("jalr illegal", {pc_src_e, illegal_e}, 32'd1);
`endif
    step(NOP, 0, 0, 0);
    step(NOP, 0, 0, 0);
    @(negedge clk);
`ifdef PIPE_CU_JUMP_EN
    chk("jalr writeback", {result_src_w, reg_write_w, rd_w}, {24'd0, 2'd2, 1'b1, 5'd1});
`else
    chk("illegal jalr no write", {26'd0, reg_write_w, rd_w}, 32'd0);
`endif

    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 249) != 0);
      if (!last_stall) instr_d = rand_instr();
      zero_e = 1'($urandom);
      lt_e   = 1'($urandom);
      ltu_e  = 1'($urandom);
    end
    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
